// File: rtl/mul_seq_ctrl.sv
// Sequential W x W unsigned multiplier built around a single 2-bit multiplier.
// Optional build macro: MUL_SEQ_ZERO_SKIP_EN (zero operands skip straight to DONE).

module mul_2b (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  assign p = {2'b00, a} * {2'b00, b};
endmodule

module mul_seq_ctrl #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p
);

  localparam int unsigned N  = W / 2;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    ra_q, ra_d, rb_q, rb_d;
  logic [IW-1:0]   i_q, i_d, j_q, j_d;
  logic [2*W-1:0]  acc_q, acc_d;

  logic [1:0]      da, db;
  logic [3:0]      pp;
  logic [2*W-1:0]  pp_ext;
  int unsigned     sh;
  logic            last_i, last_j;

  assign da     = ra_q[2*int'(i_q) +: 2];
  assign db     = rb_q[2*int'(j_q) +: 2];
  assign pp_ext = (2*W)'(pp);
  assign sh     = 2 * (int'(i_q) + int'(j_q));
  assign last_i = (i_q == IW'(N - 1));
  assign last_j = (j_q == IW'(N - 1));
  assign p      = acc_q;

  mul_2b u_mul_2b (
    .a (da),
    .b (db),
    .p (pp)
  );

  always_comb begin
    state_d   = state_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    i_d       = i_q;
    j_d       = j_q;
    acc_d     = acc_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ra_d    = a;
          rb_d    = b;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = StRun;
`ifdef MUL_SEQ_ZERO_SKIP_EN
          if (a == '0 || b == '0) state_d = StDone;
`endif
        end
      end
      StRun: begin
        acc_d = acc_q + (pp_ext << sh);
        if (last_j) begin
          j_d = '0;
          if (last_i) state_d = StDone;
          else        i_d = i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ra_q    <= '0;
      rb_q    <= '0;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Randomized self-checking bench for mul_seq_ctrl with a cycle-count reference model.
// Honours MUL_SEQ_ZERO_SKIP_EN when the build defines it.

module tb_mul_seq_ctrl;

  localparam int unsigned W = 8;
  localparam int unsigned N = W / 2;
`ifdef MUL_SEQ_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic           clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]   a, b;
  logic [2*W-1:0] p;

  int errors = 0;
  int checks = 0;

  mul_seq_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] xa, input logic [W-1:0] xb);
    if (ZS && (xa == 0 || xb == 0)) return 1;
    return N * N + 1;
  endfunction

  // Reference model: idle / busy for N*N cycles / done, product from plain arithmetic.
  bit             m_busy, m_done;
  int             m_left;
  logic [2*W-1:0] m_p;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_left = 0;
      m_p    = '0;
    end else if (!m_busy && !m_done) begin
      if (in_valid) begin
        m_p = (2*W)'(a) * (2*W)'(b);
        if (ZS && (a == 0 || b == 0)) m_done = 1'b1;
        else begin
          m_busy = 1'b1;
          m_left = N * N;
        end
      end
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else if (out_ready) begin
      m_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", 64'(in_ready), 64'(!m_busy && !m_done));
      chk("out_valid", 64'(out_valid), 64'(m_done));
      if (m_done) chk("p", 64'(p), 64'(m_p));
    end
  end

  // One transaction: present operands, wait for out_valid, optionally stall the consumer.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input bit noise,
                        input bit bp, output int lat, output logic [2*W-1:0] res);
    int cyc;
    in_valid = 1'b1;
    a = xa;
    b = xb;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      if (noise) begin
        in_valid = 1'($urandom);
        a = W'($urandom);
        b = W'($urandom);
      end
      out_ready = bp ? 1'b0 : 1'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    lat = cyc;
    res = p;
    if (!out_valid) chk("timeout_out_valid", 64'(out_valid), 64'd1);
    if (bp) begin
      out_ready = 1'b0;
      repeat (5) begin
        @(posedge clk); #1;
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_p", 64'(p), 64'((2*W)'(xa) * (2*W)'(xb)));
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_hs_in_ready", 64'(in_ready), 64'd1);
    chk("post_hs_out_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [2*W-1:0] res;
    logic [W-1:0] ra, rb;

    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_p", 64'(p), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(8'd3, 8'd5, 1'b0, 1'b0, lat, res);
    chk("3x5_p", 64'(res), 64'd15);
    chk("3x5_lat", 64'(lat), 64'd17);

    run_op(8'd255, 8'd255, 1'b0, 1'b0, lat, res);
    chk("255x255_p", 64'(res), 64'hFE01);

    run_op(8'd200, 8'd100, 1'b0, 1'b1, lat, res);
    chk("200x100_p", 64'(res), 64'd20000);

    run_op(8'd13, 8'd11, 1'b1, 1'b0, lat, res);
    chk("busy_reject_p", 64'(res), 64'd143);
    chk("busy_reject_lat", 64'(lat), 64'd17);

    // Reset in the seventh RUN cycle of a 50x60 operation.
    in_valid = 1'b1;
    a = 8'd50;
    b = 8'd60;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_p", 64'(p), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(8'd9, 8'd9, 1'b0, 1'b0, lat, res);
    chk("9x9_p", 64'(res), 64'd81);
    chk("9x9_lat", 64'(lat), 64'd17);

    run_op(8'd0, 8'd77, 1'b0, 1'b0, lat, res);
    chk("0x77_p", 64'(res), 64'd0);
    chk("0x77_lat", 64'(lat), 64'(ZS ? 1 : 17));

    for (int k = 0; k < 1500; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 9) == 0) ra = '0;
      if ($urandom_range(0, 9) == 0) rb = '0;
      if (k < 4) begin
        ra = (k[0]) ? 8'hFF : 8'h01;
        rb = (k[1]) ? 8'hFF : 8'h80;
      end
      run_op(ra, rb, ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0), lat, res);
      chk("rand_p", 64'(res), 64'((2*W)'(ra) * (2*W)'(rb)));
      chk("rand_lat", 64'(lat), 64'(exp_lat(ra, rb)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
